// File: rtl/kt_pkg.sv
// kt_pkg: shared command encodings, headings, responses and sequencer states for KnightsTour.
package kt_pkg;
    localparam logic [3:0] OP_MOVE    = 4'h4;
    localparam logic [3:0] OP_MOVE_FF = 4'h5;
    localparam logic [7:0] HDG_N      = 8'h00;
    localparam logic [7:0] HDG_W      = 8'h3F;
    localparam logic [7:0] HDG_S      = 8'h7F;
    localparam logic [7:0] HDG_E      = 8'hBF;
    localparam logic [7:0] ACK        = 8'hA5;
    localparam logic [7:0] TOUR_ACK   = 8'h5A;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VERT   = 3'd1,
        WAIT_V = 3'd2,
        HORZ   = 3'd3,
        WAIT_H = 3'd4
    } state_t;
endpackage

// File: rtl/tour_cmd_seq_move_decode.sv
// move_decode: one-hot knight move -> vertical move command and horizontal fanfare command.
module move_decode
    import kt_pkg::*;
(
    input  logic [7:0]  move,
    output logic [15:0] vert_cmd,
    output logic [15:0] horz_cmd
);
    logic       one_hot;
    logic [7:0] sel;
    logic       north, vert_2, east, horz_2;
    // Anything that is not exactly one bit falls back to move bit0.
    assign one_hot  = (move != 8'h00) && ((move & (move - 8'h01)) == 8'h00);
    assign sel      = one_hot ? move : 8'h01;
    assign north    = sel[0] | sel[1] | sel[2] | sel[7];
    assign vert_2   = sel[0] | sel[1] | sel[4] | sel[5];
    assign east     = sel[0] | sel[5] | sel[6] | sel[7];
    assign horz_2   = sel[2] | sel[3] | sel[6] | sel[7];
    assign vert_cmd = {OP_MOVE, north ? HDG_N : HDG_S, vert_2 ? 4'd2 : 4'd1};
    assign horz_cmd = {OP_MOVE_FF, east ? HDG_E : HDG_W, horz_2 ? 4'd2 : 4'd1};
endmodule

// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: muxes UART commands to cmd_proc, or sequences a solved knight's tour
// as vertical-then-horizontal move commands, handshaking on clr_cmd_rdy/send_resp.
module tour_cmd_seq
    import kt_pkg::*;
#(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);
    localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);
    state_t      state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic        tour_mode_q, tour_mode_d;
    logic [15:0] vert_cmd, horz_cmd;
    logic        last;
    move_decode u_move_decode (
        .move     (move),
        .vert_cmd (vert_cmd),
        .horz_cmd (horz_cmd)
    );
    assign last = mv_indx_q >= LAST;
    always_comb begin
        state_d     = state_q;
        mv_indx_d   = mv_indx_q;
        tour_mode_d = tour_mode_q;
        case (state_q)
            IDLE: if (start_tour) begin
                state_d     = VERT;
                mv_indx_d   = 5'd0;
                tour_mode_d = 1'b1;
            end
            VERT:   if (clr_cmd_rdy) state_d = WAIT_V;
            WAIT_V: if (send_resp) state_d = HORZ;
            HORZ:   if (clr_cmd_rdy) state_d = WAIT_H;
            WAIT_H: if (send_resp) begin
                if (last) begin
                    state_d     = IDLE;
                    tour_mode_d = 1'b0;
                end else begin
                    state_d   = VERT;
                    mv_indx_d = mv_indx_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mv_indx_q   <= 5'd0;
            tour_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mv_indx_q   <= mv_indx_d;
            tour_mode_q <= tour_mode_d;
        end
    end
    assign mv_indx = mv_indx_q;
    assign cmd     = !tour_mode_q ? cmd_UART :
                     (state_q == HORZ || state_q == WAIT_H) ? horz_cmd : vert_cmd;
    assign cmd_rdy = !tour_mode_q ? cmd_rdy_UART : (state_q == VERT || state_q == HORZ);
    // The last acknowledgement of a tour reads as a plain ACK to signal completion.
    assign resp    = (!tour_mode_q || (state_q == WAIT_H && last)) ? ACK : TOUR_ACK;
endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Sequences a pre-solved knight's tour into movement commands for cmd_proc.
- Sits between UART_wrapper, TourLogic and cmd_proc inside KnightsTour.
- In UART mode it passes remote commands straight through.
- In tour mode it splits each one-hot knight move from TourLogic into a vertical move, then a horizontal move with fanfare. It waits for cmd_proc's completion before issuing the next command.

Parameters:
NUM_MOVES, 24, moves in a tour (5x5 board); mv_indx terminal value is NUM_MOVES-1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start_tour  in  1  one-cycle pulse from cmd_proc: tour solved, begin sequencing
move  in  8  one-hot move for current mv_indx, supplied by TourLogic
mv_indx  out  5  index of move being executed
cmd_UART  in  16  command from UART_wrapper
cmd_rdy_UART  in  1  UART command valid
clr_cmd_rdy  in  1  cmd_proc consumed current command
send_resp  in  1  cmd_proc finished a command, one-cycle pulse
cmd  out  16  command presented to cmd_proc
cmd_rdy  out  1  command valid to cmd_proc
resp  out  8  response byte to UART_wrapper

Behaviour:
- Command format:
  - cmd[15:12] = opcode: 4 = move, 5 = move with fanfare.
  - cmd[11:4] = heading: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
  - cmd[3:0] = squares.
- Move decode, +y = north, tabulated as move bit: dy,dx:
  - bit0: +2,+1
  - bit1: +2,-1
  - bit2: +1,-2
  - bit3: -1,-2
  - bit4: -2,-1
  - bit5: -2,+1
  - bit6: -1,+2
  - bit7: +1,+2
- A non-one-hot move (zero or multi-bit) decodes as bit0; this is a don't-care for the solver.
- Generated commands:
  - Vertical: {4'h4, N or S heading, |dy|}.
  - Horizontal: {4'h5, E or W heading, |dx|}.
- States:
  - IDLE: UART mode. cmd = cmd_UART, cmd_rdy = cmd_rdy_UART. start_tour -> VERT, mv_indx <= 0.
  - VERT: cmd = vertical cmd, cmd_rdy = 1. On clr_cmd_rdy -> WAIT_V.
  - WAIT_V: cmd_rdy = 0. On send_resp -> HORZ.
  - HORZ: cmd = horizontal cmd, cmd_rdy = 1. On clr_cmd_rdy -> WAIT_H.
  - WAIT_H: on send_resp:
    - if mv_indx == NUM_MOVES-1 -> IDLE;
    - else mv_indx++ and -> VERT.
- Mux select:
  - Registered tour_mode flag: set on start_tour, cleared on the final send_resp.
  - While tour_mode = 1, cmd_rdy_UART is ignored (no pass-through, no queuing).
- resp:
  - In UART mode, resp = 8'hA5 (positive ack).
  - In tour mode, resp = 8'h5A, except on the final send_resp of the tour, where it is 8'hA5.
  - resp is combinational from state and mv_indx; valid in the cycle send_resp is high.
- move is sampled combinationally. TourLogic holds it stable while mv_indx is stable. No latency from a mv_indx change to a new cmd beyond one clk.
- Reset values (rst_n low, any time including mid-tour): state = IDLE, mv_indx = 0, tour_mode = 0. The robot abandons the tour; cmd_proc's own reset handles motion.
- Simultaneous events:
  - start_tour while already in tour mode is ignored.
  - send_resp in VERT/HORZ, before clr_cmd_rdy, is ignored.
  - clr_cmd_rdy in WAIT states is ignored.
- Implementation: counter of 5 bits with saturating compare; no wrap past NUM_MOVES-1.

Decomposition:
- Package kt_pkg:
  - opcode constants (OP_MOVE = 4'h4, OP_MOVE_FF = 4'h5);
  - heading constants (HDG_N/W/S/E);
  - typedef enum for states;
  - response constants ACK = 8'hA5, TOUR_ACK = 8'h5A.
- Sub-module move_decode: combinational, move[7:0] -> vertical cmd[15:0], horizontal cmd[15:0]. Testable standalone.

Test Plan:
- Reset, then cmd_UART = 16'h43F1, cmd_rdy_UART = 1 -> cmd = 16'h43F1, cmd_rdy = 1 same cycle; resp = 8'hA5 on send_resp.
- start_tour with move = 8'h01 -> cmd = 16'h4002, cmd_rdy = 1. After clr_cmd_rdy, cmd_rdy drops. After send_resp: resp = 8'h5A, then cmd = 16'h5BF1.
- Sweep move over all 8 one-hot values, for example:
  - bit3 -> 16'h47F1 then 16'h53F2;
  - bit6 -> 16'h47F1 then 16'h5BF2.
  - All eight vertical/horizontal pairs must match the decode table.
- Full tour with NUM_MOVES = 24 and an always-acking cmd_proc model:
  - mv_indx steps 0..23;
  - 48 commands issued;
  - final resp = 8'hA5;
  - state returns to IDLE and UART pass-through resumes.
- Mid-tour cmd_rdy_UART = 1 with cmd_UART = 16'h2000 -> ignored, cmd still the tour command; the stray send_resp pulse in VERT does not advance state.
- Assert rst_n low in WAIT_H at mv_indx = 10 -> mv_indx = 0, cmd_rdy follows cmd_rdy_UART (UART mode) the next cycle.
